// File: rtl/booth_pp_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : booth_pp_gen_if
//  Brief    : Operand-in / partial-product-out handshake bundle for booth_pp_gen.
//  Revision : 1.0  initial release
// ============================================================================
interface booth_pp_gen_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pp0;
    logic [31:0] pp1;
    logic [31:0] pp2;
    logic [31:0] pp3;
    logic [31:0] pp4;
    logic [31:0] pp5;
    logic [31:0] pp6;
    logic [31:0] pp7;
    logic        busy;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, busy,
        input  pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, busy,
        output pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7
    );
endinterface
`default_nettype wire

// File: rtl/booth_pp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : booth_pp_gen
//  Brief    : Two-stage pipelined radix-4 Booth partial-product generator,
//             16x16 signed operands, eight sign-extended 32-bit products.
//  Revision : 1.0  initial release
// ============================================================================
module booth_pp_gen (
    input  wire logic     clk,
    input  wire logic     rst_n,
    booth_pp_gen_if.slave bus
);
    localparam int NUM_PP = 8;

    logic        s1_valid_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        s2_valid_q;
    logic [31:0] pp_q [NUM_PP];
    logic [31:0] pp_d [NUM_PP];

    logic        adv1;
    logic        adv2;
    logic [16:0] b_ext;
    logic [31:0] a_sx;
    logic [31:0] a_sx2;

    // in_ready depends combinationally on out_ready so a full pipe can
    // drain and refill on the same edge without a bubble.
    always_comb begin
        adv2 = !s2_valid_q | bus.out_ready;
        adv1 = !s1_valid_q | adv2;
    end

    always_comb begin
        b_ext = {b_q, 1'b0};
        a_sx  = {{16{a_q[15]}}, a_q};
        a_sx2 = {a_sx[30:0], 1'b0};
    end

    for (genvar i = 0; i < NUM_PP; i++) begin : g_digit
        logic [2:0] sel;
        always_comb begin
            sel = b_ext[2*i +: 3];
            case (sel)
                3'b001, 3'b010: pp_d[i] = a_sx;
                3'b011:         pp_d[i] = a_sx2;
                3'b100:         pp_d[i] = -a_sx2;
                3'b101, 3'b110: pp_d[i] = -a_sx;
                default:        pp_d[i] = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= 16'd0;
            b_q        <= 16'd0;
            s2_valid_q <= 1'b0;
            for (int k = 0; k < NUM_PP; k++) begin
                pp_q[k] <= 32'd0;
            end
        end else begin
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                for (int k = 0; k < NUM_PP; k++) begin
                    pp_q[k] <= pp_d[k];
                end
            end
            if (adv1) begin
                s1_valid_q <= bus.in_valid;
                a_q        <= bus.op_a;
                b_q        <= bus.op_b;
            end
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.busy      = s1_valid_q | s2_valid_q;
    assign bus.pp0       = pp_q[0];
    assign bus.pp1       = pp_q[1];
    assign bus.pp2       = pp_q[2];
    assign bus.pp3       = pp_q[3];
    assign bus.pp4       = pp_q[4];
    assign bus.pp5       = pp_q[5];
    assign bus.pp6       = pp_q[6];
    assign bus.pp7       = pp_q[7];
endmodule
`default_nettype wire

// File: tb/tb_booth_pp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_pp_gen
//  Brief    : Directed self-checking bench for booth_pp_gen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth_pp_gen;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    booth_pp_gen_if bus ();

    booth_pp_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] pp_obs [8];
    assign pp_obs[0] = bus.pp0;
    assign pp_obs[1] = bus.pp1;
    assign pp_obs[2] = bus.pp2;
    assign pp_obs[3] = bus.pp3;
    assign pp_obs[4] = bus.pp4;
    assign pp_obs[5] = bus.pp5;
    assign pp_obs[6] = bus.pp6;
    assign pp_obs[7] = bus.pp7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Digit value written arithmetically: -2*b[2i+1] + b[2i] + b[2i-1].
    function automatic logic [31:0] model_pp(input logic [15:0] a, input logic [15:0] b, input int i);
        logic [16:0] bx;
        int          d;
        bx = {b, 1'b0};
        d  = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
        return 32'(d * int'($signed(a)));
    endfunction

    function automatic logic [31:0] obs_sum();
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 8; i++) s = s + (pp_obs[i] << (2 * i));
        return s;
    endfunction

    task automatic check_set(input string tag, input logic [15:0] a, input logic [15:0] b);
        chk({tag, "_ovalid"}, 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_pp%0d", tag, i), pp_obs[i], model_pp(a, b, i));
        end
        chk({tag, "_sum"}, obs_sum(), 32'(int'($signed(a)) * int'($signed(b))));
    endtask

    task automatic offer(input logic v, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = v;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    logic [15:0] va [4];
    logic [15:0] vb [4];

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        offer(1'b0, 16'd0, 16'd0);
        va[0] = 16'h1234; vb[0] = 16'h5678;
        va[1] = 16'hFFFF; vb[1] = 16'h0003;
        va[2] = 16'hABCD; vb[2] = 16'h7FFF;
        va[3] = 16'h8001; vb[3] = 16'hA5A5;

        // Reset state
        #2;
        chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",   32'(bus.busy),      32'd0);
        chk("rst_iready", 32'(bus.in_ready),  32'd1);
        chk("rst_pp0",    bus.pp0,            32'd0);
        chk("rst_pp7",    bus.pp7,            32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // 3 * 5
        bus.out_ready = 1'b1;
        offer(1'b1, 16'd3, 16'd5);
        tick();
        offer(1'b0, 16'd0, 16'd0);
        chk("v1_lat_early", 32'(bus.out_valid), 32'd0);
        chk("v1_busy",      32'(bus.busy),      32'd1);
        tick();
        chk("v1_ovalid", 32'(bus.out_valid), 32'd1);
        chk("v1_pp0",    bus.pp0, 32'd3);
        chk("v1_pp1",    bus.pp1, 32'd3);
        chk("v1_pp2",    bus.pp2, 32'd0);
        chk("v1_pp7",    bus.pp7, 32'd0);
        chk("v1_sum",    obs_sum(), 32'd15);
        tick();
        chk("v1_drain", 32'(bus.out_valid), 32'd0);

        // 0x8000 * 0x8000
        offer(1'b1, 16'h8000, 16'h8000);
        tick();
        offer(1'b0, 16'd0, 16'd0);
        tick();
        chk("v2_ovalid", 32'(bus.out_valid), 32'd1);
        chk("v2_pp0",    bus.pp0, 32'd0);
        chk("v2_pp6",    bus.pp6, 32'd0);
        chk("v2_pp7",    bus.pp7, 32'h0001_0000);
        chk("v2_sum",    obs_sum(), 32'h4000_0000);

        // 0x7FFF * 0xFFFF
        offer(1'b1, 16'h7FFF, 16'hFFFF);
        tick();
        offer(1'b0, 16'd0, 16'd0);
        tick();
        chk("v3_ovalid", 32'(bus.out_valid), 32'd1);
        chk("v3_pp0",    bus.pp0, 32'hFFFF_8001);
        chk("v3_pp1",    bus.pp1, 32'd0);
        chk("v3_pp7",    bus.pp7, 32'd0);
        chk("v3_sum",    obs_sum(), 32'hFFFF_8001);
        tick();

        // Back-to-back stream of four pairs
        for (int k = 0; k < 5; k++) begin
            if (k < 4) offer(1'b1, va[k], vb[k]);
            else       offer(1'b0, 16'd0, 16'd0);
            if (k < 4) chk($sformatf("s_iready%0d", k), 32'(bus.in_ready), 32'd1);
            tick();
            if (k >= 1) check_set($sformatf("s%0d", k - 1), va[k-1], vb[k-1]);
        end
        tick();
        chk("s_drain", 32'(bus.out_valid), 32'd0);

        // Stall: out_ready low for five edges, three pairs offered
        bus.out_ready = 1'b0;
        offer(1'b1, va[0], vb[0]);
        tick();
        offer(1'b1, va[1], vb[1]);
        tick();
        offer(1'b1, va[2], vb[2]);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("st_iready%0d", k), 32'(bus.in_ready), 32'd0);
            check_set($sformatf("st_hold%0d", k), va[0], vb[0]);
            tick();
        end
        chk("st_iready_last", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("st_iready_comb", 32'(bus.in_ready), 32'd1);
        tick();
        offer(1'b0, 16'd0, 16'd0);
        check_set("st_out1", va[1], vb[1]);
        tick();
        check_set("st_out2", va[2], vb[2]);
        tick();
        chk("st_drain", 32'(bus.out_valid), 32'd0);
        chk("st_busy",  32'(bus.busy),      32'd0);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        offer(1'b1, va[3], vb[3]);
        tick();
        offer(1'b1, va[2], vb[2]);
        tick();
        offer(1'b0, 16'd0, 16'd0);
        chk("r_full_ovalid", 32'(bus.out_valid), 32'd1);
        chk("r_full_iready", 32'(bus.in_ready),  32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_ovalid", 32'(bus.out_valid), 32'd0);
        chk("r_busy",   32'(bus.busy),      32'd0);
        chk("r_iready", 32'(bus.in_ready),  32'd1);
        for (int i = 0; i < 8; i++) chk($sformatf("r_pp%0d", i), pp_obs[i], 32'd0);
        bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("r_nostale%0d", k), 32'(bus.out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
